// File: rtl/stream_to_memory_mc_if.sv
// Avalon-MM burst write bus between the multi-channel stream writer and the DDR interconnect.
interface stream_to_memory_mc_if #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned WIDTHB = 8
);
   localparam int unsigned WIDTHBE = WIDTH / 8;

   logic [31:0]        m_address;
   logic [WIDTHBE-1:0] m_byteenable;
   logic [WIDTH-1:0]   m_writedata;
   logic [WIDTHB-1:0]  m_burstcount;
   logic               m_write;
   logic               m_waitrequest;

   modport master (
      output m_address, m_byteenable, m_writedata, m_burstcount, m_write,
      input  m_waitrequest
   );

   modport slave (
      input  m_address, m_byteenable, m_writedata, m_burstcount, m_write,
      output m_waitrequest
   );
endinterface

// File: rtl/stream_to_memory_mc.sv
// Multi-channel stream-to-memory writer: per-channel FIFOs and contexts sharing one round-robin burst master.
// Optional interrupt ports and status enabled by defining STREAM_TO_MEMORY_MC_IRQ_EN.
module stream_to_memory_mc #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned WIDTHB     = 8,
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned FIFO_DEPTH = 512,
   localparam int unsigned WIDTHF    = $clog2(FIFO_DEPTH)
) (
   input  logic                             clock,
   input  logic                             clock_areset_n,
`ifdef STREAM_TO_MEMORY_MC_IRQ_EN
   output logic                             irq,
   input  logic [CHANNELS-1:0]              irq_clear,
`endif
   input  logic [CHANNELS-1:0]              go,
   input  logic [CHANNELS-1:0]              flush,
   output logic [CHANNELS-1:0]              busy,
   output logic [CHANNELS-1:0]              done,
   input  logic [CHANNELS-1:0][31:0]        pointer,
   input  logic [CHANNELS-1:0][23:0]        word_size,
   input  logic [CHANNELS-1:0][WIDTHB-1:0]  burst_count,
   stream_to_memory_mc_if.master            avm,
   input  logic [CHANNELS-1:0]              fifo_wrreq,
   input  logic [CHANNELS-1:0][WIDTH-1:0]   fifo_data,
   output logic [CHANNELS-1:0][WIDTHF-1:0]  fifo_usedw
);
   localparam int unsigned WIDTHBE = WIDTH / 8;
   localparam int unsigned WIDTHC  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned WIDTHN  = WIDTHF + 1;

   typedef enum logic {ARB, BURST} state_t;

   logic [1:0]                      rst_sync;
   logic                            rst_n;
   logic [WIDTH-1:0]                mem [CHANNELS][FIFO_DEPTH];
   logic [CHANNELS-1:0][WIDTHF-1:0] wr_ptr, rd_ptr;
   logic [CHANNELS-1:0][WIDTHN-1:0] cnt, cnt_nxt;
   logic [CHANNELS-1:0]             wr_ok, rd_ok;
   state_t                          state;
   logic [WIDTHC-1:0]               grant, last_grant, pick, rr_idx;
   logic                            pick_vld, beat_ok;
   logic [WIDTHB-1:0]               beats;
   logic [CHANNELS-1:0]             ctx_active, ctx_flush, elig;
   logic [CHANNELS-1:0][31:0]       ctx_addr;
   logic [CHANNELS-1:0][23:0]       ctx_rem;
   logic [CHANNELS-1:0][WIDTHB-1:0] ctx_burst, len;

   // Reset asserts asynchronously, releases on a clock edge.
   always_ff @(posedge clock or negedge clock_areset_n) begin
      if (!clock_areset_n) rst_sync <= '0;
      else                 rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign beat_ok            = (state == BURST) && avm.m_write && !avm.m_waitrequest;
   assign busy               = ctx_active;
   assign avm.m_byteenable   = '1;
   assign avm.m_writedata    = (state == BURST) ? mem[grant][rd_ptr[grant]] : '0;

   // FIFO bookkeeping; writes to a full FIFO are dropped.
   always_comb begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
         wr_ok[c]      = fifo_wrreq[c] && (cnt[c] != WIDTHN'(FIFO_DEPTH));
         rd_ok[c]      = beat_ok && (grant == WIDTHC'(c));
         cnt_nxt[c]    = cnt[c] + WIDTHN'(wr_ok[c]) - WIDTHN'(rd_ok[c]);
         fifo_usedw[c] = cnt[c][WIDTHF-1:0];
      end
   end

   always_ff @(posedge clock) begin
      for (int c = 0; c < int'(CHANNELS); c++)
         if (wr_ok[c]) mem[c][wr_ptr[c]] <= fifo_data[c];
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         for (int c = 0; c < int'(CHANNELS); c++) begin
            if (wr_ok[c]) wr_ptr[c] <= wr_ptr[c] + WIDTHF'(1);
            if (rd_ok[c]) rd_ptr[c] <= rd_ptr[c] + WIDTHF'(1);
            cnt[c] <= cnt_nxt[c];
         end
      end
   end

   // Burst length and eligibility per context, then round-robin pick after the last grant.
   always_comb begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
         len[c] = (32'(ctx_rem[c]) < 32'(ctx_burst[c])) ? WIDTHB'(ctx_rem[c]) : ctx_burst[c];
         if (ctx_flush[c] && (32'(cnt[c]) < 32'(len[c]))) len[c] = WIDTHB'(cnt[c]);
         elig[c] = ctx_active[c] &&
                   (ctx_flush[c] ? (cnt[c] != '0) : (32'(cnt[c]) >= 32'(len[c])));
      end
      pick_vld = 1'b0;
      pick     = '0;
      rr_idx   = last_grant;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         rr_idx = (32'(rr_idx) == CHANNELS - 1) ? '0 : rr_idx + WIDTHC'(1);
         if (!pick_vld && elig[rr_idx]) begin
            pick_vld = 1'b1;
            pick     = rr_idx;
         end
      end
   end

   // Context loading plus the ARB/BURST master.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ARB;
         grant            <= '0;
         last_grant       <= '0;
         beats            <= '0;
         avm.m_write      <= 1'b0;
         avm.m_address    <= '0;
         avm.m_burstcount <= '0;
         ctx_active       <= '0;
         ctx_flush        <= '0;
         ctx_addr         <= '0;
         ctx_rem          <= '0;
         ctx_burst        <= '0;
         done             <= '0;
      end else begin
         done <= '0;
         for (int c = 0; c < int'(CHANNELS); c++) begin
            if (!ctx_active[c] && (go[c] || flush[c])) begin
               if (word_size[c] == '0) begin
                  done[c] <= 1'b1;
               end else begin
                  ctx_active[c] <= 1'b1;
                  ctx_flush[c]  <= flush[c];
                  ctx_addr[c]   <= pointer[c];
                  ctx_rem[c]    <= word_size[c];
                  ctx_burst[c]  <= (burst_count[c] == '0) ? WIDTHB'(1) : burst_count[c];
               end
            end
         end
         case (state)
            ARB: begin
               if (pick_vld) begin
                  grant            <= pick;
                  last_grant       <= pick;
                  beats            <= len[pick];
                  avm.m_write      <= 1'b1;
                  avm.m_address    <= ctx_addr[pick];
                  avm.m_burstcount <= len[pick];
                  ctx_rem[pick]    <= ctx_rem[pick] - 24'(len[pick]);
                  state            <= BURST;
               end
            end
            BURST: begin
               if (beat_ok) begin
                  beats <= beats - WIDTHB'(1);
                  if (beats == WIDTHB'(1)) begin
                     avm.m_write     <= 1'b0;
                     state           <= ARB;
                     ctx_addr[grant] <= ctx_addr[grant] + 32'(avm.m_burstcount) * 32'(WIDTHBE);
                     // A flush context with nothing left buffered finishes early.
                     if ((ctx_rem[grant] == '0) || (ctx_flush[grant] && (cnt_nxt[grant] == '0))) begin
                        ctx_active[grant] <= 1'b0;
                        done[grant]       <= 1'b1;
                     end
                  end
               end
            end
            default: state <= ARB;
         endcase
      end
   end

`ifdef STREAM_TO_MEMORY_MC_IRQ_EN
   logic [CHANNELS-1:0] irq_status, irq_status_nxt;

   // A completion in the same cycle as a clear keeps the status bit set.
   assign irq_status_nxt = (irq_status & ~irq_clear) | done;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         irq_status <= '0;
         irq        <= 1'b0;
      end else begin
         irq_status <= irq_status_nxt;
         irq        <= |irq_status_nxt;
      end
   end
`else
   // Interrupt status logic is compiled out in this build.
`endif
endmodule
